// File: rtl/fpau_pkg.sv
// Shared FPAU definitions: datapath widths, power-engine state encoding and
// a few FP32 constants.
package fpau_pkg;

    localparam int FP_W  = 32;
    localparam int SEL_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [31:0] ONE = 32'h3F800000;
    localparam logic [31:0] TWO = 32'h40000000;

endpackage

// File: rtl/multiplier.sv
// Combinational FP32 multiplier: round-to-nearest-even, denormal inputs read as
// zero, underflow flushes to signed zero, overflow saturates to infinity.
module multiplier (
    output logic [31:0] out,
    input  logic [31:0] a,
    input  logic [31:0] b
);

    logic               s;
    logic [7:0]         ea, eb;
    logic [22:0]        fa, fb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]        prod;
    logic [23:0]        mant;
    logic               guard, sticky, rnd;
    logic [24:0]        mant_r;
    logic signed [10:0] exp_s;

    always_comb begin
        s      = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        fa     = a[22:0];
        fb     = b[22:0];
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);

        prod  = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
        exp_s = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127;

        // Product of two [1,2) significands lies in [1,4): normalise by one bit at most.
        if (prod[47]) begin
            mant   = prod[47:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_s  = exp_s + 11'sd1;
        end else begin
            mant   = prod[46:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end

        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {24'd0, rnd};
        if (mant_r[24]) begin
            mant  = mant_r[24:1];
            exp_s = exp_s + 11'sd1;
        end else begin
            mant = mant_r[23:0];
        end

        out = {s, exp_s[7:0], mant[22:0]};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            out = 32'h7FC00000;
        end else if (a_inf || b_inf) begin
            out = {s, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            out = {s, 31'd0};
        end else if (exp_s >= 11'sd255) begin
            out = {s, 8'hFF, 23'd0};
        end else if (exp_s <= 11'sd0) begin
            out = {s, 31'd0};
        end
    end

endmodule

// File: rtl/fp_pow_seq.sv
// Sequential FP32 integer-power engine: out = in^(sel+1) using one shared
// multiplier, accumulating acc = acc*in exactly sel times.
module fp_pow_seq #(
    parameter int FP_W  = fpau_pkg::FP_W,
    parameter int SEL_W = fpau_pkg::SEL_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FP_W-1:0]      in,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FP_W-1:0]      out,
    output logic                 busy,
    output fpau_pkg::state_e     dbg_state_o
);

    import fpau_pkg::*;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and a DONE result stays stable
    // until out_ready is seen.

    state_e           state_q, state_d;
    logic [FP_W-1:0]  acc_q, acc_d;
    logic [FP_W-1:0]  op_q, op_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [FP_W-1:0]  mul_out;

    multiplier u_mul (
        .out (mul_out),
        .a   (acc_q),
        .b   (op_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;

        // flush only redirects the FSM; datapath registers keep their values.
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d    = in;
                        acc_d   = in;
                        cnt_d   = sel;
                        state_d = (sel == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    acc_d = mul_out;
                    cnt_d = cnt_q - SEL_W'(1);
                    if (cnt_q == SEL_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign out         = acc_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp_pow_seq.sv
// Directed and randomized bench for fp_pow_seq against a real-arithmetic
// reference of repeated FP32 multiplication.
module tb_fp_pow_seq;

    import fpau_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      din;
    logic [4:0]       sel;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      dout;
    logic             busy;
    state_e           dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    fp_pow_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in          (din),
        .sel         (sel),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (dout),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: exact product in double precision, then rounded to FP32.
    function automatic real f32_to_real(input logic [31:0] x);
        logic [10:0] de;
        de = 11'(int'(x[30:23]) + 896);
        return $bitstoreal({x[31], de, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        real         p;
        logic [63:0] pb;
        logic [28:0] low;
        int          e, be, sig;
        logic [31:0] sigv;
        s      = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
        if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        p   = f32_to_real(a) * f32_to_real(b);
        pb  = $realtobits(p);
        e   = int'(pb[62:52]) - 1023;
        sig = int'({1'b1, pb[51:29]});
        low = pb[28:0];
        if (low > 29'h10000000 || (low == 29'h10000000 && pb[29])) sig++;
        if (sig == (1 << 24)) begin
            sig = sig >> 1;
            e++;
        end
        be = e + 127;
        if (be >= 255) return {s, 8'hFF, 23'd0};
        if (be <= 0) return {s, 31'd0};
        sigv = sig;
        return {s, 8'(be), sigv[22:0]};
    endfunction

    function automatic logic [31:0] ref_pow(input logic [31:0] x, input int s);
        logic [31:0] acc;
        acc = x;
        for (int i = 0; i < s; i++) acc = ref_mul(acc, x);
        return acc;
    endfunction

    // Driver: submit one request, check latency, result and return to IDLE.
    task automatic run_op(input logic [31:0] x, input logic [4:0] s, input int stall, input string tag);
        int k;
        logic [31:0] held;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        exp_q.push_back(ref_pow(x, int'(s)));
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        din       = x;
        sel       = s;
        @(negedge clk);
        in_valid = 1'b0;
        din      = $urandom;
        sel      = 5'($urandom);
        k = 1;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, 32'(k), 32'(int'(s) + 1));
        held = exp_q.pop_front();
        check({tag, "_out"}, dout, held);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_stall_out"}, dout, held);
            check({tag, "_stall_vld"}, {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] x, held;
        logic [4:0]  s;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        din       = '0;
        sel       = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out", dout, 32'd0);
        check("rst_flags", {29'd0, busy, out_valid, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(TWO, 5'd4, 0, "t1_pow5");
        check("t1_val", ref_pow(TWO, 4), 32'h42000000);
        run_op(32'hC0490FDB, 5'd0, 0, "t2_sel0");
        run_op(ONE, 5'd31, 0, "t2_one31");
        run_op(TWO, 5'd31, 0, "t3_two32");
        check("t3_val", ref_pow(TWO, 31), 32'h4F800000);
        run_op(32'h7F000000, 5'd1, 0, "t3_ovf");

        // Backpressure: result held, new requests refused.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din       = 32'h40400000;
        sel       = 5'd2;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_vld", {31'd0, out_valid}, 32'd1);
        held = dout;
        check("t4_val", held, 32'h41D80000);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            din      = $urandom;
            sel      = 5'($urandom);
            @(negedge clk);
            check("t4_hold_out", dout, held);
            check("t4_hold_flags", {30'd0, out_valid, in_ready}, 32'd2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_release", {29'd0, busy, out_valid, in_ready}, 32'd1);

        // Flush on the 5th RUN cycle.
        in_valid = 1'b1;
        din      = TWO;
        sel      = 5'd20;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            check("t5_run_vld", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t5_flushed", {29'd0, busy, out_valid, in_ready}, 32'd1);
        repeat (20) begin
            @(negedge clk);
            check("t5_no_vld", {31'd0, out_valid}, 32'd0);
        end
        run_op(TWO, 5'd2, 0, "t5_after");
        check("t5_val", ref_pow(TWO, 2), 32'h41000000);

        // flush in IDLE blocks acceptance.
        flush    = 1'b1;
        in_valid = 1'b1;
        din      = TWO;
        sel      = 5'd3;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_idle", {30'd0, busy, in_ready}, 32'd1);

        // flush in DONE with out_ready: consumed, back to IDLE.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 5'd0;
        @(negedge clk);
        in_valid = 1'b0;
        check("flush_done_vld", {31'd0, out_valid}, 32'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_idle", {29'd0, busy, out_valid, in_ready}, 32'd1);

        // Asynchronous reset mid-RUN.
        in_valid = 1'b1;
        din      = 32'h3FC00000;
        sel      = 5'd15;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_out", dout, 32'd0);
        check("t6_rst_flags", {29'd0, busy, out_valid, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized: mostly moderate exponents so long chains keep significant bits.
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 9))
                0:       x = $urandom;
                1:       x = {1'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : 255), 23'($urandom_range(0, 3) == 0 ? 0 : $urandom)};
                default: x = {1'($urandom), 8'($urandom_range(118, 136)), 23'($urandom)};
            endcase
            s = 5'($urandom_range(0, 31));
            run_op(x, s, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, "rand");
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
